// File: rtl/alu_muldiv_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers for the mul/div units.
// Used by the combinational ALU, decode and the sequential mul/div unit.
package alu_muldiv_pkg;

    typedef logic [4:0] opc_t;

    localparam opc_t OP_MUL    = 5'b01001;
    localparam opc_t OP_MULH   = 5'b01010;
    localparam opc_t OP_MULHU  = 5'b01011;
    localparam opc_t OP_MULHSU = 5'b01100;
    localparam opc_t OP_DIV    = 5'b01101;
    localparam opc_t OP_DIVU   = 5'b01110;
    localparam opc_t OP_REM    = 5'b01111;
    localparam opc_t OP_REMU   = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    // The mul/div opcodes form one contiguous range, with the divides at its top.
    function automatic logic is_muldiv(input opc_t op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(input opc_t op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_rem(input opc_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input opc_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input opc_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_shift_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step, N steps.
// No handshake: start loads operands, step advances one bit, done pulses on the final step.
module muldiv_shift_core #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic           div_mode,
    input  logic [N-1:0]   opa,
    input  logic [N-1:0]   opb,
    output logic           done,
    output logic [2*N-1:0] prod,
    output logic [N-1:0]   quo,
    output logic [N-1:0]   rem
);
    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt;
    logic          mode;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [N-1:0]  b;
    logic [N:0]    sum;
    logic [N:0]    r_sh;
    logic [N-1:0]  diff;
    logic          ge;

    // hi holds the upper accumulator (multiply) or partial remainder (divide);
    // lo holds the multiplier being shifted out or the quotient being shifted in.
    assign sum  = {1'b0, hi} + {1'b0, b};
    assign r_sh = {hi, lo[N-1]};
    assign ge   = (r_sh >= {1'b0, b});
    assign diff = r_sh[N-1:0] - b;

    assign done = step && (cnt == '0);
    assign prod = {hi, lo};
    assign quo  = lo;
    assign rem  = hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            mode <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            b    <= '0;
        end else if (start) begin
            cnt  <= CW'(N - 1);
            mode <= div_mode;
            hi   <= '0;
            lo   <= opa;
            b    <= opb;
        end else if (step) begin
            cnt <= cnt - CW'(1);
            if (mode) begin
                hi <= ge ? diff : r_sh[N-1:0];
                lo <= {lo[N-2:0], ge};
            end else if (lo[0]) begin
                {hi, lo} <= {sum, lo[N-1:1]};
            end else begin
                {hi, lo} <= {1'b0, hi, lo[N-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M mul/div unit: N+2 cycles for real ops, 1 cycle for div-by-zero/non-muldiv.
// Single op in flight; result held until out_ready, flush aborts, no back-to-back issue.
import alu_muldiv_pkg::*;

module alu_muldiv_seq #(
    parameter int N     = 32,
    parameter int OPC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] alu_opcode,
    input  logic [N-1:0]     rega,
    input  logic [N-1:0]     regb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     alu_res_muldiv,
    output logic             flag_divbyzero
);
    state_t         state;
    opc_t           op_in;
    opc_t           op_q;
    logic           accept;
    logic           sa;
    logic           sb;
    logic           div_zero;
    logic           core_start;
    logic           core_step;
    logic           core_done;
    logic           sign_q;
    logic           sign_r;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;

    assign op_in      = opc_t'(alu_opcode);
    assign in_ready   = (state == ST_IDLE);
    assign accept     = in_valid && in_ready && !flush;
    assign sa         = is_signed_a(op_in) && rega[N-1];
    assign sb         = is_signed_b(op_in) && regb[N-1];
    assign mag_a      = sa ? -rega : rega;
    assign mag_b      = sb ? -regb : regb;
    assign div_zero   = is_div(op_in) && (regb == '0);
    assign core_start = accept && is_muldiv(op_in) && !div_zero;
    assign core_step  = (state == ST_CALC) && !flush;

    // sign_q doubles as the product sign for multiplies.
    assign prod_fix = sign_q ? -prod : prod;
    assign q_fix    = sign_q ? -quo : quo;
    assign r_fix    = sign_r ? -rem : rem;

    muldiv_shift_core #(.N(N)) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .step     (core_step),
        .div_mode (is_div(op_in)),
        .opa      (mag_a),
        .opb      (mag_b),
        .done     (core_done),
        .prod     (prod),
        .quo      (quo),
        .rem      (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            out_valid      <= 1'b0;
            alu_res_muldiv <= '0;
            flag_divbyzero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        sign_q <= sa ^ sb;
                        sign_r <= sa;
                        if (!is_muldiv(op_in)) begin
                            alu_res_muldiv <= '0;
                            flag_divbyzero <= 1'b0;
                            out_valid      <= 1'b1;
                            state          <= ST_DONE;
                        end else if (div_zero) begin
                            alu_res_muldiv <= is_rem(op_in) ? rega : '1;
                            flag_divbyzero <= 1'b1;
                            out_valid      <= 1'b1;
                            state          <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush)          state <= ST_IDLE;
                    else if (core_done) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (is_div(op_q))
                            alu_res_muldiv <= is_rem(op_q) ? r_fix : q_fix;
                        else if (op_q == OP_MUL)
                            alu_res_muldiv <= prod_fix[N-1:0];
                        else
                            alu_res_muldiv <= prod_fix[2*N-1:N];
                        flag_divbyzero <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: RV32M results, latency, output hold, flush and async reset.
module tb_alu_muldiv_seq;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    alu_opcode;
    logic [N-1:0]  rega;
    logic [N-1:0]  regb;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  alu_res_muldiv;
    logic          flag_divbyzero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.N(N), .OPC_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_opcode     (alu_opcode),
        .rega           (rega),
        .regb           (regb),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_res_muldiv (alu_res_muldiv),
        .flag_divbyzero (flag_divbyzero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) from the negedge after acceptance until out_valid; returns cycles since acceptance cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] er, input logic ef,
                          input int elat);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid   = 1'b1;
        alu_opcode = op;
        rega       = a;
        regb       = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, 64'(alu_res_muldiv), 64'(er));
        chk({tag, "_flag"}, 64'(flag_divbyzero), 64'(ef));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        alu_opcode = '0;
        rega       = '0;
        regb       = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_res", 64'(alu_res_muldiv), 64'(0));
        chk("rst_flag", 64'(flag_divbyzero), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",      5'b01001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, N + 2);
        run_op("mulh",     5'b01010, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, N + 2);
        run_op("mulhu",    5'b01011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, N + 2);
        run_op("mulhsu",   5'b01100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, N + 2);
        run_op("div",      5'b01101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, N + 2);
        run_op("rem",      5'b01111, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, N + 2);
        run_op("div_ovf",  5'b01101, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, N + 2);
        run_op("rem_ovf",  5'b01111, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, N + 2);
        run_op("divu_dbz", 5'b01110, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1);
        run_op("remu_dbz", 5'b10000, 32'd5,        32'd0,        32'd5,        1'b1, 1);
        run_op("remu",     5'b10000, 32'd100,      32'd7,        32'd2,        1'b0, N + 2);
        run_op("non_md",   5'b00001, 32'd9,        32'd3,        32'd0,        1'b0, 1);

        // Output hold under backpressure, then immediate reissue after release.
        @(negedge clk);
        in_valid = 1'b1; alu_opcode = 5'b01001; rega = 32'd3; regb = 32'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("hold_latency", 64'(lat), 64'(N + 2));
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_res", 64'(alu_res_muldiv), 64'(15));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'(1));
        chk("release_out_valid", 64'(out_valid), 64'(0));
        in_valid = 1'b1; alu_opcode = 5'b01110; rega = 32'd100; regb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("reissue_accepted", 64'(in_ready), 64'(0));
        wait_valid(lat);
        chk("reissue_res", 64'(alu_res_muldiv), 64'(14));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush mid-CALC: no result may ever appear.
        in_valid = 1'b1; alu_opcode = 5'b01101; rega = 32'd100; regb = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_calc_in_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_calc_no_valid", 64'(seen), 64'(0));

        // Flush while holding a result in DONE.
        in_valid = 1'b1; alu_opcode = 5'b01110; rega = 32'd5; regb = 32'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_done_pre_valid", 64'(out_valid), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_valid", 64'(out_valid), 64'(0));
        chk("flush_done_in_ready", 64'(in_ready), 64'(1));

        // Flush beats a simultaneous request in IDLE.
        in_valid = 1'b1; flush = 1'b1; alu_opcode = 5'b01110; rega = 32'd5; regb = 32'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", 64'(in_ready), 64'(1));
        chk("flush_idle_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-CALC; result register still holds the last completed value.
        in_valid = 1'b1; alu_opcode = 5'b01001; rega = 32'd11; regb = 32'd13;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_res", 64'(alu_res_muldiv), 64'hFFFFFFFF);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_res", 64'(alu_res_muldiv), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_mul", 5'b01001, 32'd11, 32'd13, 32'd143, 1'b0, N + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
